// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: owns divisor, half-period counter and div_out,
// and applies configuration changes only on half-period boundaries.
module clk_div_ctrl #(
  parameter int CW          = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_div,
  input  logic          cfg_en,
  output logic          div_out,
  output logic          tick,
  output logic          busy,
  output logic [CW-1:0] div_cur,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] div_reg;
  logic [CW-1:0] pend_div_reg;
  logic          pend_en_reg;
  logic          div_out_reg;
  logic          tick_reg;
  logic          err_reg;

  logic accept;
  logic cfg_bad;
  logic boundary;

  assign cfg_ready = !rst && (state_reg != PEND);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_div == '0);
  assign boundary  = (state_reg != IDLE) && (cnt_reg == div_reg - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      div_reg      <= CW'(DEFAULT_DIV);
      pend_div_reg <= '0;
      pend_en_reg  <= 1'b0;
      div_out_reg  <= 1'b0;
      tick_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      // A zero divisor is rejected outright and leaves everything else alone.
      err_reg  <= accept && cfg_bad;
      tick_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          div_out_reg <= 1'b0;
          if (accept && !cfg_bad) begin
            div_reg <= cfg_div;
            if (cfg_en) state_reg <= RUN;
          end
        end
        RUN, PEND: begin
          if (boundary) begin
            cnt_reg     <= '0;
            div_out_reg <= ~div_out_reg;
            tick_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
          if (state_reg == RUN) begin
            if (accept && !cfg_bad) begin
              pend_div_reg <= cfg_div;
              pend_en_reg  <= cfg_en;
              state_reg    <= PEND;
            end
          end else if (boundary) begin
            // Stopping waits for the falling boundary so the last high phase is full width.
            if (pend_en_reg) begin
              div_reg   <= pend_div_reg;
              state_reg <= RUN;
            end else if (div_out_reg) begin
              div_reg   <= pend_div_reg;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign div_out = div_out_reg;
  assign tick    = tick_reg;
  assign err     = err_reg;
  assign busy    = (state_reg != IDLE);
  assign div_cur = div_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected tick/err events are queued by
// the stimulus and consumed by a monitor whenever the DUT pulses them.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic       div_out;
  logic       tick;
  logic       busy;
  logic [7:0] div_cur;
  logic       err;

  clk_div_ctrl #(.CW(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_en(cfg_en),
    .div_out(div_out), .tick(tick), .busy(busy),
    .div_cur(div_cur), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic dout;
    int   dcur;
    logic bsy;
  } ev_t;

  ev_t exp_q[$];
  int  err_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic d, input int dc, input logic b);
    ev_t e;
    e.cyc = c; e.dout = d; e.dcur = dc; e.bsy = b;
    exp_q.push_back(e);
  endtask

  // Monitor: every tick and err pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (tick) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_div_out", int'(div_out), int'(e.dout));
        check("tick_div_cur", int'(div_cur), e.dcur);
        check("tick_busy", int'(busy), int'(e.bsy));
        $display("tick @%0d div_out=%0d div_cur=%0d busy=%0d", cyc, div_out, div_cur, busy);
      end
    end
    if (err) begin
      if (err_q.size() == 0) begin
        check("unexpected_err", 1, 0);
      end else begin
        check("err_cycle", cyc, err_q.pop_front());
        $display("err  @%0d", cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic accept(input int d, input logic en, output int e0);
    cfg_div   = 8'(d);
    cfg_en    = en;
    cfg_valid = 1'b1;
    check("ready_before_accept", int'(cfg_ready), 1);
    @(posedge clk);
    #1;
    e0 = cyc;
    cfg_valid = 1'b0;
    $display("cfg  @%0d div=%0d en=%0d", e0, d, en);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, e;
    rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_div_out", int'(div_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_div_cur", int'(div_cur), 4);
    check("rst_ready", int'(cfg_ready), 0);
    rst = 1'b0;
    #1 check("ready_after_rst", int'(cfg_ready), 1);

    // Start with div=4: rise at +4, fall at +8, period 8.
    accept(4, 1'b1, b);
    check("busy_after_start", int'(busy), 1);
    push(b+4, 1, 4, 1); push(b+8, 0, 4, 1); push(b+12, 1, 4, 1); push(b+16, 0, 4, 1);

    // Reconfigure to 2 two cycles after the toggle at b+16.
    wait_cyc(b+17);
    accept(2, 1'b1, e);
    check("ready_in_pend", int'(cfg_ready), 0);
    push(b+20, 1, 2, 1); push(b+22, 0, 2, 1); push(b+24, 1, 2, 1); push(b+26, 0, 2, 1);
    wait_cyc(b+20);
    check("ready_after_pend", int'(cfg_ready), 1);
    check("div_cur_new", int'(div_cur), 2);

    // Switch to div=3, then stop while div_out is low.
    wait_cyc(b+26);
    accept(3, 1'b1, e);
    push(b+28, 1, 3, 1); push(b+31, 0, 3, 1);
    wait_cyc(b+31);
    check("low_before_stop", int'(div_out), 0);
    accept(3, 1'b0, e);
    push(b+34, 1, 3, 1); push(b+37, 0, 3, 0);
    wait_cyc(b+36);
    check("busy_during_stop", int'(busy), 1);
    wait_cyc(b+40);
    check("busy_after_stop", int'(busy), 0);
    check("div_out_after_stop", int'(div_out), 0);

    // Zero divisor in IDLE.
    accept(0, 1'b1, e);
    err_q.push_back(e);
    @(negedge clk);
    check("idle_err_div_cur", int'(div_cur), 3);
    check("idle_err_busy", int'(busy), 0);
    check("idle_err_ready", int'(cfg_ready), 1);

    // Zero divisor in RUN must not disturb the waveform.
    accept(4, 1'b1, b);
    push(b+4, 1, 4, 1); push(b+8, 0, 4, 1); push(b+12, 1, 4, 1);
    wait_cyc(b+5);
    accept(0, 1'b0, e);
    err_q.push_back(e);
    check("run_err_ready", int'(cfg_ready), 1);

    // Move to div=5, then reset asynchronously in the high phase.
    wait_cyc(b+12);
    accept(5, 1'b1, e);
    push(b+16, 0, 5, 1); push(b+21, 1, 5, 1);
    wait_cyc(b+23);
    check("high_before_rst", int'(div_out), 1);
    rst = 1'b1;
    #1;
    check("async_div_out", int'(div_out), 0);
    check("async_tick", int'(tick), 0);
    check("async_busy", int'(busy), 0);
    check("async_div_cur", int'(div_cur), 4);
    check("async_ready", int'(cfg_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // div=1: toggle every edge with tick held high, then stop.
    accept(1, 1'b1, b);
    push(b+1, 1, 1, 1); push(b+2, 0, 1, 1); push(b+3, 1, 1, 1); push(b+4, 0, 1, 1);
    push(b+5, 1, 1, 1); push(b+6, 0, 1, 0);
    wait_cyc(b+4);
    accept(1, 1'b0, e);
    wait_cyc(b+10);
    check("final_busy", int'(busy), 0);
    check("final_div_out", int'(div_out), 0);
    check("tick_queue_drained", exp_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
